// File: rtl/piso_frame_serializer.sv
// piso_frame_serializer
// Parallel-in/serial-out frame serializer with valid/ready handshakes on
// both the parallel input and the serial output.
// Define PISO_PARITY_EN to append one even-parity beat after the data bits.
module piso_frame_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             lsb_first,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             frame_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] shreg_reg;
  logic [CW-1:0]    count_reg;
  logic             dir_reg;
`ifdef PISO_PARITY_EN
  logic             par_reg;
`endif

  logic accept;
  logic beat;
  logic last_data;

  assign last_data = (state_reg == SHIFT) && (count_reg == LAST_CNT);
  assign beat      = sout_valid & sout_ready;
  assign accept    = din_valid & din_ready;

  // State register; clr_n aborts any frame in progress
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state: a new word accepted on the final beat keeps us in SHIFT
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        if (beat && last_data) begin
`ifdef PISO_PARITY_EN
          state_next = PAR;
`else
          state_next = accept ? SHIFT : IDLE;
`endif
        end
      end
      PAR: begin
        if (beat) state_next = accept ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state and registered data; din_ready also looks at
  // sout_ready so the next word can load on the final beat with no bubble
  always_comb begin
    din_ready  = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    frame_last = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        din_ready = 1'b1;
      end
      SHIFT: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
        sout       = dir_reg ? shreg_reg[0] : shreg_reg[WIDTH-1];
`ifndef PISO_PARITY_EN
        frame_last = last_data;
        din_ready  = last_data & sout_ready;
`endif
      end
      PAR: begin
        busy = 1'b1;
`ifdef PISO_PARITY_EN
        sout_valid = 1'b1;
        sout       = par_reg;
        frame_last = 1'b1;
        din_ready  = sout_ready;
`endif
      end
      default: ;
    endcase
  end

  // Data path: load on accept, shift on each data beat, hold otherwise
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shreg_reg <= '0;
      count_reg <= '0;
      dir_reg   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else if (accept) begin
      shreg_reg <= din;
      count_reg <= '0;
      dir_reg   <= lsb_first;
`ifdef PISO_PARITY_EN
      par_reg   <= ^din;
`endif
    end else if (beat && (state_reg == SHIFT)) begin
      shreg_reg <= dir_reg ? {1'b0, shreg_reg[WIDTH-1:1]}
                           : {shreg_reg[WIDTH-2:0], 1'b0};
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed testbench for piso_frame_serializer (WIDTH=4).
// Serial sequences are written in beat order, first beat on the left.
module tb_piso_frame_serializer;

  localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam int NB = WIDTH + 1;
  localparam logic [NB-1:0] EXP_1011_MSB = 5'b10111;
  localparam logic [NB-1:0] EXP_1011_LSB = 5'b11011;
  localparam logic [NB-1:0] EXP_0110_MSB = 5'b01100;
  localparam logic [NB-1:0] EXP_0001_MSB = 5'b00011;
  localparam logic [NB-1:0] EXP_LAST     = 5'b00001;
`else
  localparam int NB = WIDTH;
  localparam logic [NB-1:0] EXP_1011_MSB = 4'b1011;
  localparam logic [NB-1:0] EXP_1011_LSB = 4'b1101;
  localparam logic [NB-1:0] EXP_0110_MSB = 4'b0110;
  localparam logic [NB-1:0] EXP_0001_MSB = 4'b0001;
  localparam logic [NB-1:0] EXP_LAST     = 4'b0001;
`endif

  logic             clk;
  logic             clr_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             lsb_first;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             frame_last;
  logic             busy;

  int total;
  int bad;

  piso_frame_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .din        (din),
    .din_valid  (din_valid),
    .lsb_first  (lsb_first),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .frame_last (frame_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one word, then record NB beats with sout_ready held high.
  // lsb_first is flipped right after accept to show it is only sampled then.
  task automatic run_frame(input logic [WIDTH-1:0] w, input logic lsb,
                           output logic [NB-1:0] seq, output logic [NB-1:0] lasts,
                           output logic [NB-1:0] vals, output logic idle_after,
                           output logic acc_ok);
    int n;
    seq = '0; lasts = '0; vals = '0;
    @(negedge clk);
    din = w; lsb_first = lsb; din_valid = 1'b1; sout_ready = 1'b1;
    #1;
    n = 0;
    while (!din_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    acc_ok = din_ready;
    @(posedge clk); #1;
    din_valid = 1'b0; lsb_first = ~lsb; din = '0;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk); #1;
      seq   = {seq[NB-2:0], sout};
      lasts = {lasts[NB-2:0], frame_last};
      vals  = {vals[NB-2:0], sout_valid};
    end
    @(negedge clk); #1;
    idle_after = !busy && !sout_valid && din_ready;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; din = '0; din_valid = 1'b0; lsb_first = 1'b0; sout_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (sout_valid !== 1'b0) begin bad++; $display("FAIL reset_sout_valid: got %b want 0", sout_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (frame_last !== 1'b0) begin bad++; $display("FAIL reset_frame_last: got %b want 0", frame_last); end
    total++; if (sout !== 1'b0) begin bad++; $display("FAIL reset_sout: got %b want 0", sout); end
    @(negedge clk); clr_n = 1'b1; #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_din_ready: got %b want 1", din_ready); end
    $display("test_reset done");
  endtask

  task automatic test_frame(input string name, input logic [WIDTH-1:0] w, input logic lsb,
                            input logic [NB-1:0] exp_seq);
    logic [NB-1:0] seq, lasts, vals;
    logic idle_after, acc_ok;
    run_frame(w, lsb, seq, lasts, vals, idle_after, acc_ok);
    total++; if (acc_ok !== 1'b1) begin bad++; $display("FAIL %s_accept: got din_ready=%b want 1", name, acc_ok); end
    total++; if (seq !== exp_seq) begin bad++; $display("FAIL %s_seq: got %b want %b", name, seq, exp_seq); end
    total++; if (lasts !== EXP_LAST) begin bad++; $display("FAIL %s_frame_last: got %b want %b", name, lasts, EXP_LAST); end
    total++; if (vals !== {NB{1'b1}}) begin bad++; $display("FAIL %s_valid: got %b want all ones", name, vals); end
    total++; if (idle_after !== 1'b1) begin bad++; $display("FAIL %s_idle_after: got %b want 1", name, idle_after); end
    $display("test_frame %s: din=%b lsb_first=%b seq=%b", name, w, lsb, seq);
  endtask

  task automatic test_backpressure();
    logic [NB-1:0] seq;
    int beats, cyc;
    seq = '0; beats = 0; cyc = 0;
    @(negedge clk);
    din = 4'b1011; lsb_first = 1'b0; din_valid = 1'b1; sout_ready = 1'b1;
    #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL bp_accept: got %b want 1", din_ready); end
    @(posedge clk); #1;
    din_valid = 1'b0;
    while (beats < NB && cyc < 30) begin
      @(negedge clk);
      sout_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        total++; if (sout !== 1'b1) begin bad++; $display("FAIL bp_hold_sout c%0d: got %b want 1", cyc, sout); end
        total++; if (sout_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid c%0d: got %b want 1", cyc, sout_valid); end
        total++; if (frame_last !== 1'b0) begin bad++; $display("FAIL bp_hold_last c%0d: got %b want 0", cyc, frame_last); end
      end
      if (sout_valid && sout_ready) begin
        seq = {seq[NB-2:0], sout};
        beats++;
      end
      cyc++;
    end
    sout_ready = 1'b1;
    total++; if (beats != NB) begin bad++; $display("FAIL bp_beats: got %0d want %0d", beats, NB); end
    total++; if (seq !== EXP_1011_MSB) begin bad++; $display("FAIL bp_seq: got %b want %b", seq, EXP_1011_MSB); end
    @(negedge clk); #1;
    $display("test_backpressure: seq=%b cycles=%0d", seq, cyc);
  endtask

  task automatic test_back_to_back();
    logic [2*NB-1:0] seq, lasts, vals;
    logic rdy_at_last;
    seq = '0; lasts = '0; vals = '0; rdy_at_last = 1'b0;
    @(negedge clk);
    din = 4'b1011; lsb_first = 1'b0; din_valid = 1'b1; sout_ready = 1'b1;
    @(posedge clk); #1;
    din = 4'b0110;
    for (int i = 0; i < 2*NB; i++) begin
      @(negedge clk);
      if (i == NB) din_valid = 1'b0;
      #1;
      seq   = {seq[2*NB-2:0], sout};
      lasts = {lasts[2*NB-2:0], frame_last};
      vals  = {vals[2*NB-2:0], sout_valid};
      if (i == NB-1) rdy_at_last = din_ready;
    end
    total++; if (rdy_at_last !== 1'b1) begin bad++; $display("FAIL b2b_din_ready_last: got %b want 1", rdy_at_last); end
    total++; if (seq !== {EXP_1011_MSB, EXP_0110_MSB}) begin bad++; $display("FAIL b2b_seq: got %b want %b", seq, {EXP_1011_MSB, EXP_0110_MSB}); end
    total++; if (lasts !== {EXP_LAST, EXP_LAST}) begin bad++; $display("FAIL b2b_frame_last: got %b want %b", lasts, {EXP_LAST, EXP_LAST}); end
    total++; if (vals !== {2*NB{1'b1}}) begin bad++; $display("FAIL b2b_no_bubble: got %b want all ones", vals); end
    @(negedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after: got busy=%b want 0", busy); end
    $display("test_back_to_back: seq=%b", seq);
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    din = 4'b1011; lsb_first = 1'b0; din_valid = 1'b1; sout_ready = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    total++; if (sout_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", sout_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    total++; if (frame_last !== 1'b0) begin bad++; $display("FAIL mid_rst_last: got %b want 0", frame_last); end
    total++; if (sout !== 1'b0) begin bad++; $display("FAIL mid_rst_sout: got %b want 0", sout); end
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_din_ready: got %b want 1", din_ready); end
    $display("test_reset_midframe: outputs cleared");
    test_frame("after_reset_0001", 4'b0001, 1'b0, EXP_0001_MSB);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_frame("msb_1011", 4'b1011, 1'b0, EXP_1011_MSB);
    test_frame("lsb_1011", 4'b1011, 1'b1, EXP_1011_LSB);
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
